// File: rtl/serial_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bit_feeder
//  Description : Parallel-to-serial source stage for the lab Moore state
//                machines. A WIDTH-bit word is accepted through a Load/Ready
//                handshake and emitted one bit per Ck on X, qualified by
//                XValid. Done pulses for one cycle at the end of each frame.
//
//  Parameters  : WIDTH      word length in bits (2..32)
//                MSB_FIRST  1: Din[WIDTH-1] leaves first, 0: Din[0] first
//
//  Build macro : SER_PARITY_EN - when defined, an even-parity bit (state PAR)
//                follows the last data bit, so the frame is WIDTH+1 bits.
//
//  Ports       : Ck       in   system clock, rising edge
//                Reset_n  in   asynchronous active-low reset
//                Load     in   accept request, honoured only while Ready=1
//                Din      in   word to serialize, sampled at the accept edge
//                Hold     in   stall; freezes SHIFT (and PAR)
//                Ready    out  1 only in IDLE
//                X        out  serial data bit
//                XValid   out  1 while X carries a frame bit
//                Busy     out  1 in any state other than IDLE
//                Done     out  one-cycle pulse in DONE
//                BitCnt   out  bits already shifted in this frame
//
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       Ck,
    input  logic                       Reset_n,
    input  logic                       Load,
    input  logic [WIDTH-1:0]           Din,
    input  logic                       Hold,
    output logic                       Ready,
    output logic                       X,
    output logic                       XValid,
    output logic                       Busy,
    output logic                       Done,
    output logic [$clog2(WIDTH+1)-1:0] BitCnt
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef SER_PARITY_EN
        ST_PAR   = 2'd2,
`endif
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
`ifdef SER_PARITY_EN
    logic               par_q,   par_d;
`endif

    logic               w_head_bit;
    logic [WIDTH-1:0]   w_shifted;

    // The head bit is the one currently on X; shifting moves the next bit
    // into the head position and back-fills with zero.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head_bit = shreg_q[WIDTH-1];
            assign w_shifted  = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head_bit = shreg_q[0];
            assign w_shifted  = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge Ck or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef SER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Load) begin
                    shreg_d = Din;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
`ifdef SER_PARITY_EN
                    // Parity is taken from the captured word, since the
                    // shifter no longer holds it by the time PAR is reached.
                    par_d   = ^Din;
`endif
                end
            end
            ST_SHIFT: begin
                if (!Hold) begin
                    shreg_d = w_shifted;
                    cnt_d   = cnt_q + c_cnt_one;
                    if (cnt_q == c_cnt_last) begin
`ifdef SER_PARITY_EN
                        state_d = ST_PAR;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef SER_PARITY_EN
            ST_PAR: begin
                if (!Hold) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Moore outputs: decoded from registered state and shifter only
    // ------------------------------------------------------------------------
    always_comb begin
        Ready  = 1'b0;
        Busy   = 1'b1;
        Done   = 1'b0;
        XValid = 1'b0;
        X      = 1'b0;
        BitCnt = cnt_q;
        case (state_q)
            ST_IDLE: begin
                Ready = 1'b1;
                Busy  = 1'b0;
            end
            ST_SHIFT: begin
                XValid = 1'b1;
                X      = w_head_bit;
            end
`ifdef SER_PARITY_EN
            ST_PAR: begin
                XValid = 1'b1;
                X      = par_q;
            end
`endif
            ST_DONE: begin
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_bit_feeder
//  Description : Self-checking bench for serial_bit_feeder. Two instances
//                (MSB-first and LSB-first) share the same stimulus; expected
//                serial bits are queued when a word is driven and compared
//                as the instances emit them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_bit_feeder;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    localparam logic [3:0] ST_IDLE_V  = 4'b1000;  // {Ready,Busy,XValid,Done}
    localparam logic [3:0] ST_SHIFT_V = 4'b0110;
    localparam logic [3:0] ST_DONE_V  = 4'b0101;

    logic             Ck = 1'b0;
    logic             Reset_n;
    logic             Load;
    logic [WIDTH-1:0] Din;
    logic             Hold;

    logic             m_Ready, m_X, m_XValid, m_Busy, m_Done;
    logic [CNT_W-1:0] m_BitCnt;
    logic             l_Ready, l_X, l_XValid, l_Busy, l_Done;
    logic [CNT_W-1:0] l_BitCnt;

    logic [CNT_W+3:0] m_st, l_st;
    assign m_st = {m_Ready, m_Busy, m_XValid, m_Done, m_BitCnt};
    assign l_st = {l_Ready, l_Busy, l_XValid, l_Done, l_BitCnt};

    int checks = 0;
    int errors = 0;
    bit q_msb[$];
    bit q_lsb[$];

    always #5 Ck = ~Ck;

    serial_bit_feeder #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
        .Ck(Ck), .Reset_n(Reset_n), .Load(Load), .Din(Din), .Hold(Hold),
        .Ready(m_Ready), .X(m_X), .XValid(m_XValid), .Busy(m_Busy),
        .Done(m_Done), .BitCnt(m_BitCnt)
    );

    serial_bit_feeder #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
        .Ck(Ck), .Reset_n(Reset_n), .Load(Load), .Din(Din), .Hold(Hold),
        .Ready(l_Ready), .X(l_X), .XValid(l_XValid), .Busy(l_Busy),
        .Done(l_Done), .BitCnt(l_BitCnt)
    );

    // Scoreboard: every valid bit is compared against the queue head; the
    // head is consumed only when the coming edge is not a Hold edge.
    always @(negedge Ck) begin
        if (m_XValid === 1'b1) begin
            checks++;
            if (q_msb.size() == 0) begin
                errors++;
                $display("FAIL sb_msb_extra got XValid=1 X=%0b required no frame bit", m_X);
            end else begin
                if (m_X !== q_msb[0]) begin
                    errors++;
                    $display("FAIL sb_msb_x got %0b required %0b", m_X, q_msb[0]);
                end
                if (Hold == 1'b0) void'(q_msb.pop_front());
            end
        end
        if (l_XValid === 1'b1) begin
            checks++;
            if (q_lsb.size() == 0) begin
                errors++;
                $display("FAIL sb_lsb_extra got XValid=1 X=%0b required no frame bit", l_X);
            end else begin
                if (l_X !== q_lsb[0]) begin
                    errors++;
                    $display("FAIL sb_lsb_x got %0b required %0b", l_X, q_lsb[0]);
                end
                if (Hold == 1'b0) void'(q_lsb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge Ck);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) begin
            q_msb.push_back(w[WIDTH-1-i]);
            q_lsb.push_back(w[i]);
        end
`ifdef SER_PARITY_EN
        q_msb.push_back(^w);
        q_lsb.push_back(^w);
`endif
    endtask

    // Drives one accept edge; returns one step after that edge.
    task automatic accept(input logic [WIDTH-1:0] w);
        Load = 1'b1;
        Din  = w;
        push_word(w);
        tick();
        Load = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Load    = 1'b1;
        Din     = 8'hFF;
        Hold    = 1'b0;
        repeat (3) tick();
        checks++;
        if ({m_st, l_st} !== {ST_IDLE_V, CNT_W'(0), ST_IDLE_V, CNT_W'(0)}) begin
            errors++;
            $display("FAIL reset_state got %b/%b required %b", m_st, l_st, {ST_IDLE_V, CNT_W'(0)});
        end
        checks++;
        if ({m_X, l_X} !== 2'b00) begin
            errors++;
            $display("FAIL reset_x got %b required 00", {m_X, l_X});
        end
        Load    = 1'b0;
        Reset_n = 1'b1;
        repeat (2) tick();
        checks++;
        if ({m_st, l_st} !== {ST_IDLE_V, CNT_W'(0), ST_IDLE_V, CNT_W'(0)}) begin
            errors++;
            $display("FAIL idle_no_load got %b/%b required %b", m_st, l_st, {ST_IDLE_V, CNT_W'(0)});
        end
    endtask

    task automatic test_patterns();
        logic [WIDTH-1:0] words [6];
        words[0] = 8'hB4;
        words[1] = 8'h00;
        words[2] = 8'hFF;
        words[3] = 8'hB5;
        words[4] = WIDTH'($urandom);
        words[5] = WIDTH'($urandom);
        for (int w = 0; w < 6; w++) begin
            accept(words[w]);
            for (int i = 0; i < WIDTH; i++) begin
                checks++;
                if ({m_st, l_st} !== {ST_SHIFT_V, CNT_W'(i), ST_SHIFT_V, CNT_W'(i)}) begin
                    errors++;
                    $display("FAIL frame_shift w=%h i=%0d got %b/%b required %b",
                             words[w], i, m_st, l_st, {ST_SHIFT_V, CNT_W'(i)});
                end
                tick();
            end
`ifdef SER_PARITY_EN
            checks++;
            if ({m_st, m_X, l_st, l_X} !==
                {ST_SHIFT_V, CNT_W'(WIDTH), ^words[w], ST_SHIFT_V, CNT_W'(WIDTH), ^words[w]}) begin
                errors++;
                $display("FAIL frame_parity w=%h got %b%b/%b%b required %b%b", words[w],
                         m_st, m_X, l_st, l_X, {ST_SHIFT_V, CNT_W'(WIDTH)}, ^words[w]);
            end
            tick();
`endif
            checks++;
            if ({m_st, m_X, l_st, l_X} !==
                {ST_DONE_V, CNT_W'(WIDTH), 1'b0, ST_DONE_V, CNT_W'(WIDTH), 1'b0}) begin
                errors++;
                $display("FAIL frame_done w=%h got %b%b/%b%b required %b0", words[w],
                         m_st, m_X, l_st, l_X, {ST_DONE_V, CNT_W'(WIDTH)});
            end
            tick();
            checks++;
            if ({m_st[CNT_W+3:CNT_W], l_st[CNT_W+3:CNT_W]} !== {ST_IDLE_V, ST_IDLE_V}) begin
                errors++;
                $display("FAIL frame_ready w=%h got %b/%b required %b", words[w],
                         m_st[CNT_W+3:CNT_W], l_st[CNT_W+3:CNT_W], ST_IDLE_V);
            end
        end
    endtask

    task automatic test_hold();
        accept(8'hB4);
        repeat (2) tick();
        Hold = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if ({m_st, l_st} !== {ST_SHIFT_V, CNT_W'(2), ST_SHIFT_V, CNT_W'(2)}) begin
                errors++;
                $display("FAIL hold_frozen j=%0d got %b/%b required %b", j, m_st, l_st,
                         {ST_SHIFT_V, CNT_W'(2)});
            end
        end
        Hold = 1'b0;
        for (int i = 3; i < FRAME; i++) tick();
        tick();
        checks++;
        if ({m_st, l_st} !== {ST_DONE_V, CNT_W'(WIDTH), ST_DONE_V, CNT_W'(WIDTH)}) begin
            errors++;
            $display("FAIL hold_done_delay got %b/%b required %b", m_st, l_st,
                     {ST_DONE_V, CNT_W'(WIDTH)});
        end
        Hold = 1'b1;   // no effect in DONE
        tick();
        Hold = 1'b0;
        checks++;
        if ({m_st[CNT_W+3:CNT_W], l_st[CNT_W+3:CNT_W]} !== {ST_IDLE_V, ST_IDLE_V}) begin
            errors++;
            $display("FAIL hold_in_done got %b/%b required %b", m_st[CNT_W+3:CNT_W],
                     l_st[CNT_W+3:CNT_W], ST_IDLE_V);
        end
    endtask

    task automatic test_load_ignored();
        accept(8'h3C);
        for (int i = 0; i < FRAME; i++) begin
            Load = (i == 3);
            Din  = 8'hFF;
            tick();
        end
        Load = 1'b0;
        checks++;
        if ({m_st, l_st} !== {ST_DONE_V, CNT_W'(WIDTH), ST_DONE_V, CNT_W'(WIDTH)}) begin
            errors++;
            $display("FAIL load_in_shift got %b/%b required %b", m_st, l_st,
                     {ST_DONE_V, CNT_W'(WIDTH)});
        end
        Load = 1'b1;
        Din  = 8'h81;
        tick();
        Load = 1'b0;
        tick();
        checks++;
        if ({m_st[CNT_W+3:CNT_W], l_st[CNT_W+3:CNT_W]} !== {ST_IDLE_V, ST_IDLE_V}) begin
            errors++;
            $display("FAIL load_in_done got %b/%b required %b", m_st[CNT_W+3:CNT_W],
                     l_st[CNT_W+3:CNT_W], ST_IDLE_V);
        end
        accept(8'h81);
        checks++;
        if ({m_st, l_st} !== {ST_SHIFT_V, CNT_W'(0), ST_SHIFT_V, CNT_W'(0)}) begin
            errors++;
            $display("FAIL load_after_ready got %b/%b required %b", m_st, l_st,
                     {ST_SHIFT_V, CNT_W'(0)});
        end
        repeat (FRAME + 1) tick();
    endtask

    task automatic test_back_to_back();
        accept(8'hC3);
        Load = 1'b1;          // held high across the whole first frame
        Din  = 8'h5A;
        push_word(8'h5A);
        repeat (FRAME) tick();
        checks++;
        if ({m_st, l_st} !== {ST_DONE_V, CNT_W'(WIDTH), ST_DONE_V, CNT_W'(WIDTH)}) begin
            errors++;
            $display("FAIL b2b_done1 got %b/%b required %b", m_st, l_st,
                     {ST_DONE_V, CNT_W'(WIDTH)});
        end
        tick();
        checks++;
        if ({m_st[CNT_W+3:CNT_W], l_st[CNT_W+3:CNT_W]} !== {ST_IDLE_V, ST_IDLE_V}) begin
            errors++;
            $display("FAIL b2b_ready got %b/%b required %b", m_st[CNT_W+3:CNT_W],
                     l_st[CNT_W+3:CNT_W], ST_IDLE_V);
        end
        tick();
        Load = 1'b0;
        checks++;
        if ({m_st, l_st} !== {ST_SHIFT_V, CNT_W'(0), ST_SHIFT_V, CNT_W'(0)}) begin
            errors++;
            $display("FAIL b2b_accept2 got %b/%b required %b", m_st, l_st,
                     {ST_SHIFT_V, CNT_W'(0)});
        end
        repeat (FRAME + 1) tick();
    endtask

    task automatic test_reset_mid();
        accept(8'hA7);
        repeat (3) tick();
        #2;
        Reset_n = 1'b0;
        q_msb.delete();
        q_lsb.delete();
        #1;
        checks++;
        if ({m_st, m_X, l_st, l_X} !==
            {ST_IDLE_V, CNT_W'(0), 1'b0, ST_IDLE_V, CNT_W'(0), 1'b0}) begin
            errors++;
            $display("FAIL reset_async got %b%b/%b%b required %b0", m_st, m_X, l_st, l_X,
                     {ST_IDLE_V, CNT_W'(0)});
        end
        Load = 1'b1;
        Din  = 8'hFF;
        tick();
        checks++;
        if ({m_st, l_st} !== {ST_IDLE_V, CNT_W'(0), ST_IDLE_V, CNT_W'(0)}) begin
            errors++;
            $display("FAIL reset_beats_load got %b/%b required %b", m_st, l_st,
                     {ST_IDLE_V, CNT_W'(0)});
        end
        Load = 1'b0;
        #3;
        Reset_n = 1'b1;
        repeat (FRAME + 3) tick();
        checks++;
        if ({m_st, l_st} !== {ST_IDLE_V, CNT_W'(0), ST_IDLE_V, CNT_W'(0)}) begin
            errors++;
            $display("FAIL reset_no_resume got %b/%b required %b", m_st, l_st,
                     {ST_IDLE_V, CNT_W'(0)});
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_hold();
        test_load_ignored();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if ((q_msb.size() != 0) || (q_lsb.size() != 0)) begin
            errors++;
            $display("FAIL sb_drain got %0d/%0d pending bits required 0", q_msb.size(), q_lsb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
